pwm_duty_capture: RTL and testbench



---
 rtl/pwm_duty_capture.sv | 233 +++++++++++++++++++++++
 tb/tb_pwm_duty_capture.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_capture.sv
// PWM input capture: measures period and high time of a synchronized input and
// reports duty on a 0..1023 scale using a one-bit-per-cycle restoring divider.
module pwm_duty_capture #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 10000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [9:0]       duty,
    output logic [CNT_W-1:0] period,
    output logic             duty_valid,
    output logic             stuck,
    output logic             busy
);
    localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] cap_p_q, cap_p_d;
    logic [CNT_W-1:0] cap_h_q, cap_h_d;
    logic [CNT_W:0]   rem_q, rem_d;
    logic [9:0]       quo_q, quo_d;
    logic             sat_q, sat_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             armed_q, armed_d;
    logic             stuck_q, stuck_d;
    logic [9:0]       duty_q, duty_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             duty_valid_q, duty_valid_d;
    logic             busy_q, busy_d;
    state_e           state_q, state_d;

    logic             rise_s, fall_s, edge_s, timeout_s, ge_s;
    logic [CNT_W:0]   rem_sh_s;
    logic [9:0]       quo_new_s;

    assign rise_s    = sync2_q & ~prev_q;
    assign fall_s    = ~sync2_q & prev_q;
    assign edge_s    = rise_s | fall_s;
    // Stuck fires once per quiet stretch; an edge in the same cycle takes precedence.
    assign timeout_s = (idle_cnt_q == TO_C) && !edge_s && !stuck_q;

    assign duty       = duty_q;
    assign period     = period_q;
    assign duty_valid = duty_valid_q;
    assign stuck      = stuck_q;
    assign busy       = busy_q;

    // One restoring-division step; quotient bits shift in MSB first.
    always_comb begin
        rem_sh_s  = rem_q << 1'b1;
        ge_s      = (rem_sh_s >= {1'b0, cap_p_q});
        quo_new_s = {quo_q[8:0], ge_s};
    end

    // Period, high-time and edge-idle counters.
    always_comb begin
        per_cnt_d  = per_cnt_q;
        hi_cnt_d   = hi_cnt_q;
        hi_lat_d   = hi_lat_q;
        idle_cnt_d = idle_cnt_q;
        if (rise_s) begin
            per_cnt_d = ONE_C;
        end else if (per_cnt_q != TO_C) begin
            per_cnt_d = per_cnt_q + ONE_C;
        end else begin
            per_cnt_d = per_cnt_q;
        end
        if (rise_s) begin
            hi_cnt_d = ONE_C;
        end else if (sync2_q && (hi_cnt_q != TO_C)) begin
            hi_cnt_d = hi_cnt_q + ONE_C;
        end else begin
            hi_cnt_d = hi_cnt_q;
        end
        if (fall_s && armed_q) begin
            hi_lat_d = hi_cnt_q;
        end else begin
            hi_lat_d = hi_lat_q;
        end
        if (edge_s) begin
            idle_cnt_d = ONE_C;
        end else if (idle_cnt_q != TO_C) begin
            idle_cnt_d = idle_cnt_q + ONE_C;
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
    end

    // Divider FSM, arming, measurement close and stuck handling.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        sat_d        = sat_q;
        bit_idx_d    = bit_idx_q;
        cap_p_d      = cap_p_q;
        cap_h_d      = cap_h_q;
        armed_d      = armed_q;
        stuck_d      = stuck_q;
        duty_d       = duty_q;
        period_d     = period_q;
        duty_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_LOAD: begin
                rem_d     = {1'b0, cap_h_q};
                sat_d     = (cap_h_q >= cap_p_q);
                quo_d     = 10'd0;
                bit_idx_d = 4'd9;
                state_d   = ST_DIV;
            end
            ST_DIV: begin
                if (ge_s) begin
                    rem_d = rem_sh_s - {1'b0, cap_p_q};
                end else begin
                    rem_d = rem_sh_s;
                end
                quo_d = quo_new_s;
                if (bit_idx_q == 4'd0) begin
                    duty_d       = sat_q ? 10'd1023 : quo_new_s;
                    period_d     = cap_p_q;
                    duty_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    bit_idx_d = bit_idx_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rise_s) begin
            if (!armed_q) begin
                armed_d = 1'b1;
            end else if (state_q == ST_IDLE) begin
                cap_p_d = per_cnt_q;
                cap_h_d = hi_lat_q;
                state_d = ST_LOAD;
            end else begin
                armed_d = armed_q;
            end
        end else begin
            armed_d = armed_d;
        end

        if (edge_s) begin
            stuck_d = 1'b0;
        end else begin
            stuck_d = stuck_q;
        end

        // A timeout overrides any in-flight division, including its final step.
        if (timeout_s) begin
            stuck_d      = 1'b1;
            period_d     = {CNT_W{1'b0}};
            duty_d       = sync2_q ? 10'd1023 : 10'd0;
            duty_valid_d = 1'b1;
            armed_d      = 1'b0;
            state_d      = ST_IDLE;
        end else begin
            stuck_d = stuck_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            per_cnt_q    <= {CNT_W{1'b0}};
            hi_cnt_q     <= {CNT_W{1'b0}};
            hi_lat_q     <= {CNT_W{1'b0}};
            idle_cnt_q   <= {CNT_W{1'b0}};
            cap_p_q      <= {CNT_W{1'b0}};
            cap_h_q      <= {CNT_W{1'b0}};
            rem_q        <= {(CNT_W+1){1'b0}};
            quo_q        <= 10'd0;
            sat_q        <= 1'b0;
            bit_idx_q    <= 4'd0;
            armed_q      <= 1'b0;
            stuck_q      <= 1'b0;
            duty_q       <= 10'd0;
            period_q     <= {CNT_W{1'b0}};
            duty_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            sync1_q      <= pwm_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            per_cnt_q    <= per_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            hi_lat_q     <= hi_lat_d;
            idle_cnt_q   <= idle_cnt_d;
            cap_p_q      <= cap_p_d;
            cap_h_q      <= cap_h_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            sat_q        <= sat_d;
            bit_idx_q    <= bit_idx_d;
            armed_q      <= armed_d;
            stuck_q      <= stuck_d;
            duty_q       <= duty_d;
            period_q     <= period_d;
            duty_valid_q <= duty_valid_d;
            busy_q       <= busy_d;
            state_q      <= state_d;
        end
    end
endmodule

// File: tb/tb_pwm_duty_capture.sv
// Randomized bench for pwm_duty_capture: input trains are checked against an
// event-level model of arming, busy discard, latency and duty arithmetic.
module tb_pwm_duty_capture;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 10000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             pwm_in = 1'b0;
    logic [9:0]       duty;
    logic [CNT_W-1:0] period;
    logic             duty_valid, stuck, busy;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    int          lg_cyc[$];
    int          lg_duty[$];
    int unsigned lg_per[$];
    bit          lg_stuck[$];
    int          ex_cyc[$];
    int          ex_duty[$];
    int unsigned ex_per[$];
    int          rise_q[$];

    pwm_duty_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .pwm_in(pwm_in), .duty(duty), .period(period),
        .duty_valid(duty_valid), .stuck(stuck), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (duty_valid === 1'b1) begin
            lg_cyc.push_back(cyc);
            lg_duty.push_back(int'(duty));
            lg_per.push_back(period);
            lg_stuck.push_back(stuck);
        end
    end

    function automatic int ref_duty(int h, int p);
        int v;
        if (h >= p) return 1023;
        v = (h * 1024) / p;
        return (v > 1023) ? 1023 : v;
    endfunction

    task automatic clear_log();
        lg_cyc.delete(); lg_duty.delete(); lg_per.delete(); lg_stuck.delete();
    endtask

    task automatic do_reset();
        pwm_in = 1'b0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_log();
    endtask

    task automatic drive(bit lvl, int n);
        repeat (n) begin
            @(negedge clk);
            pwm_in = lvl;
        end
    endtask

    task automatic drive_train(int h, int l, int n);
        rise_q.delete();
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < h + l; k++) begin
                @(negedge clk);
                pwm_in = (k < h);
                if (k == 0) rise_q.push_back(cyc);
            end
        end
    endtask

    // First rise only arms; a rise is measured when the previous measured one is
    // more than 12 cycles back; the result appears 14 cycles after the input rise.
    task automatic model_train(int h, int l);
        int acc;
        acc = -1000;
        ex_cyc.delete(); ex_duty.delete(); ex_per.delete();
        for (int j = 1; j < rise_q.size(); j++) begin
            if (rise_q[j] - acc > 12) begin
                acc = rise_q[j];
                ex_cyc.push_back(rise_q[j] + 14);
                ex_duty.push_back(ref_duty(h, h + l));
                ex_per.push_back(h + l);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_total++; if (duty !== 10'd0) $display("FAIL reset_duty: got %0d want 0", duty); else n_pass++;
        n_total++; if (period !== '0) $display("FAIL reset_period: got %0d want 0", period); else n_pass++;
        n_total++; if (duty_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", duty_valid); else n_pass++;
        n_total++; if (stuck !== 1'b0) $display("FAIL reset_stuck: got %b want 0", stuck); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_log();
        drive(1'b0, 20);
        n_total++; if (lg_cyc.size() != 0) $display("FAIL idle_no_pulse: got %0d pulses want 0", lg_cyc.size()); else n_pass++;
    endtask

    task automatic test_measure();
        int th[9], tl[9], tn[9];
        int nh[4], nl[4];
        int m, pick;
        th = '{1000, 2929, 3, 999, 1, 0, 0, 0, 0};
        tl = '{3000, 1072, 5, 1, 1023, 0, 0, 0, 0};
        tn = '{3, 4, 10, 3, 3, 12, 4, 4, 4};
        nh = '{3, 2, 4, 1};
        nl = '{5, 5, 3, 4};
        pick = $urandom_range(3, 0);
        th[5] = nh[pick]; tl[5] = nl[pick];
        for (int c = 6; c < 9; c++) begin
            th[c] = $urandom_range(300, 1);
            tl[c] = $urandom_range(300, 19);
        end
        for (int c = 0; c < 9; c++) begin
            do_reset();
            drive(1'b0, 5);
            drive_train(th[c], tl[c], tn[c]);
            drive(1'b0, 20);
            model_train(th[c], tl[c]);
            n_total++;
            if (lg_cyc.size() != ex_cyc.size())
                $display("FAIL train%0d_count: got %0d pulses want %0d (h=%0d l=%0d)", c, lg_cyc.size(), ex_cyc.size(), th[c], tl[c]);
            else n_pass++;
            m = (lg_cyc.size() < ex_cyc.size()) ? lg_cyc.size() : ex_cyc.size();
            for (int i = 0; i < m; i++) begin
                n_total++; if (lg_cyc[i] != ex_cyc[i]) $display("FAIL train%0d_latency[%0d]: got cycle %0d want %0d", c, i, lg_cyc[i], ex_cyc[i]); else n_pass++;
                n_total++; if (lg_duty[i] != ex_duty[i]) $display("FAIL train%0d_duty[%0d]: got %0d want %0d", c, i, lg_duty[i], ex_duty[i]); else n_pass++;
                n_total++; if (lg_per[i] != ex_per[i]) $display("FAIL train%0d_period[%0d]: got %0d want %0d", c, i, lg_per[i], ex_per[i]); else n_pass++;
                n_total++; if (lg_stuck[i] != 1'b0) $display("FAIL train%0d_stuck[%0d]: got %b want 0", c, i, lg_stuck[i]); else n_pass++;
            end
        end
    endtask

    task automatic test_stuck_high();
        int c0;
        do_reset();
        drive(1'b0, 5);
        @(negedge clk);
        pwm_in = 1'b1;
        c0 = cyc;
        drive(1'b1, TIMEOUT + 30);
        n_total++; if (lg_cyc.size() != 1) $display("FAIL stuckhi_count: got %0d pulses want 1", lg_cyc.size()); else n_pass++;
        if (lg_cyc.size() > 0) begin
            n_total++; if (lg_duty[0] != 1023) $display("FAIL stuckhi_duty: got %0d want 1023", lg_duty[0]); else n_pass++;
            n_total++; if (lg_per[0] != 0) $display("FAIL stuckhi_period: got %0d want 0", lg_per[0]); else n_pass++;
            n_total++; if (lg_stuck[0] != 1'b1) $display("FAIL stuckhi_flag_at_pulse: got %b want 1", lg_stuck[0]); else n_pass++;
            n_total++;
            if (lg_cyc[0] < c0 + TIMEOUT || lg_cyc[0] > c0 + TIMEOUT + 5)
                $display("FAIL stuckhi_time: got cycle %0d want %0d..%0d", lg_cyc[0], c0 + TIMEOUT, c0 + TIMEOUT + 5);
            else n_pass++;
        end
        n_total++; if (stuck !== 1'b1) $display("FAIL stuckhi_flag: got %b want 1", stuck); else n_pass++;
        clear_log();
        drive(1'b0, 50);
        n_total++; if (stuck !== 1'b0) $display("FAIL stuckhi_clear: got %b want 0", stuck); else n_pass++;
        n_total++; if (lg_cyc.size() != 0) $display("FAIL stuckhi_clear_pulse: got %0d pulses want 0", lg_cyc.size()); else n_pass++;
        drive_train(200, 300, 2);
        drive(1'b0, 20);
        model_train(200, 300);
        n_total++; if (lg_cyc.size() != 1) $display("FAIL stuckhi_resume_count: got %0d pulses want 1", lg_cyc.size()); else n_pass++;
        if (lg_cyc.size() > 0 && ex_cyc.size() > 0) begin
            n_total++; if (lg_cyc[0] != ex_cyc[0]) $display("FAIL stuckhi_resume_latency: got %0d want %0d", lg_cyc[0], ex_cyc[0]); else n_pass++;
            n_total++; if (lg_duty[0] != ex_duty[0]) $display("FAIL stuckhi_resume_duty: got %0d want %0d", lg_duty[0], ex_duty[0]); else n_pass++;
            n_total++; if (lg_per[0] != ex_per[0]) $display("FAIL stuckhi_resume_period: got %0d want %0d", lg_per[0], ex_per[0]); else n_pass++;
        end
    endtask

    task automatic test_stuck_low();
        int c1, c2, hh, ll;
        hh = $urandom_range(40, 5);
        ll = $urandom_range(200, 40);
        do_reset();
        drive(1'b0, TIMEOUT + 30);
        n_total++; if (lg_cyc.size() != 1) $display("FAIL stucklo_count: got %0d pulses want 1", lg_cyc.size()); else n_pass++;
        if (lg_cyc.size() > 0) begin
            n_total++; if (lg_duty[0] != 0) $display("FAIL stucklo_duty: got %0d want 0", lg_duty[0]); else n_pass++;
            n_total++; if (lg_per[0] != 0) $display("FAIL stucklo_period: got %0d want 0", lg_per[0]); else n_pass++;
        end
        n_total++; if (stuck !== 1'b1) $display("FAIL stucklo_flag: got %b want 1", stuck); else n_pass++;
        clear_log();
        @(negedge clk);
        pwm_in = 1'b1;
        c1 = cyc;
        drive(1'b1, hh - 1);
        n_total++; if (stuck !== 1'b0) $display("FAIL stucklo_clear: got %b want 0", stuck); else n_pass++;
        drive(1'b0, ll);
        n_total++; if (lg_cyc.size() != 0) $display("FAIL stucklo_arm_only: got %0d pulses want 0", lg_cyc.size()); else n_pass++;
        @(negedge clk);
        pwm_in = 1'b1;
        c2 = cyc;
        drive(1'b1, 5);
        drive(1'b0, 30);
        n_total++; if (lg_cyc.size() != 1) $display("FAIL stucklo_measure_count: got %0d pulses want 1", lg_cyc.size()); else n_pass++;
        if (lg_cyc.size() > 0) begin
            n_total++; if (lg_cyc[0] != c2 + 14) $display("FAIL stucklo_measure_latency: got %0d want %0d", lg_cyc[0], c2 + 14); else n_pass++;
            n_total++; if (lg_duty[0] != ref_duty(hh, c2 - c1)) $display("FAIL stucklo_measure_duty: got %0d want %0d", lg_duty[0], ref_duty(hh, c2 - c1)); else n_pass++;
            n_total++; if (lg_per[0] != c2 - c1) $display("FAIL stucklo_measure_period: got %0d want %0d", lg_per[0], c2 - c1); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        drive(1'b0, 5);
        drive_train(50, 100, 1);
        clear_log();
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (7) @(negedge clk);
        n_total++; if (busy !== 1'b1) $display("FAIL middiv_busy: got %b want 1", busy); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (duty !== 10'd0) $display("FAIL middiv_duty: got %0d want 0", duty); else n_pass++;
        n_total++; if (period !== '0) $display("FAIL middiv_period: got %0d want 0", period); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL middiv_busy_rst: got %b want 0", busy); else n_pass++;
        n_total++; if (duty_valid !== 1'b0) $display("FAIL middiv_valid: got %b want 0", duty_valid); else n_pass++;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 30);
        n_total++; if (lg_cyc.size() != 0) $display("FAIL middiv_no_pulse: got %0d pulses want 0", lg_cyc.size()); else n_pass++;
        drive_train(60, 90, 2);
        drive(1'b0, 20);
        model_train(60, 90);
        n_total++; if (lg_cyc.size() != 1) $display("FAIL middiv_rearm_count: got %0d pulses want 1", lg_cyc.size()); else n_pass++;
        if (lg_cyc.size() > 0 && ex_cyc.size() > 0) begin
            n_total++; if (lg_cyc[0] != ex_cyc[0]) $display("FAIL middiv_rearm_latency: got %0d want %0d", lg_cyc[0], ex_cyc[0]); else n_pass++;
            n_total++; if (lg_duty[0] != ex_duty[0]) $display("FAIL middiv_rearm_duty: got %0d want %0d", lg_duty[0], ex_duty[0]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_measure();
        test_stuck_high();
        test_stuck_low();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
